// File: rtl/bk_pkg.sv
// Shared Brent-Kung definitions: default width, pipeline split level, PG bus type
// and the PG / dot-operator cells used by both the adder and subtractor datapaths.
package bk_pkg;

   localparam int BK_WIDTH_DEFAULT = 32;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Forward-tree levels 1..split are registered in S2, the rest land in S3.
   function automatic int bk_split_level(input int width);
      return clog2(width) / 2 + 1;
   endfunction

   localparam int BK_PIPE_SPLIT_LEVEL = bk_split_level(BK_WIDTH_DEFAULT);

   typedef struct packed {
      logic [BK_WIDTH_DEFAULT-1:0] p;
      logic [BK_WIDTH_DEFAULT-1:0] g;
   } pg_t;

   // PG cell: returns {g, p}.
   function automatic logic [1:0] bk_pg_cell(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   // Dot operator (hi o lo): returns {g, p}.
   function automatic logic [1:0] bk_dot(input logic g_hi, input logic p_hi,
                                         input logic g_lo, input logic p_lo);
      return {g_hi | (p_hi & g_lo), p_hi & p_lo};
   endfunction

endpackage

// File: rtl/bk_sub_stage_reg.sv
// One elastic pipeline stage: valid bit, skid-free ready logic and a payload register.
// The payload only loads on an accepted beat so it holds while the stage is stalled.
module bk_sub_stage_reg
   import bk_pkg::*;
#(
   parameter int DATA_W   = 2 * BK_WIDTH_DEFAULT,
   parameter bit RST_DATA = 1'b0
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              up_valid,
   input  logic              dn_ready,
   input  logic [DATA_W-1:0] data_d,
   output logic              valid,
   output logic              ready,
   output logic [DATA_W-1:0] data_q
);

   assign ready = ~valid | dn_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
      end else if (ready) begin
         valid <= up_valid;
      end
   end

   generate
      if (RST_DATA) begin : g_rst_data
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_q <= '0;
            end else if (ready && up_valid) begin
               data_q <= data_d;
            end
         end
      end else begin : g_plain_data
         always_ff @(posedge clk) begin
            if (ready && up_valid) begin
               data_q <= data_d;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/bk_subtractor_pipe.sv
// Three-stage Brent-Kung subtractor (diff = a - b - bin) with valid/ready on both sides.
// Define BK_SUB_SATURATE_EN to clamp diff on signed overflow instead of wrapping.
module bk_subtractor_pipe
   import bk_pkg::*;
#(
   parameter int WIDTH = BK_WIDTH_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             zero
);

   localparam int LVLS  = clog2(WIDTH);
   localparam int SPLIT = bk_split_level(WIDTH);
   localparam int S1_W  = 2 * WIDTH + 3;
   localparam int S2_W  = 3 * WIDTH + 3;
   localparam int S3_W  = WIDTH + 3;

   // Forward levels 1..SPLIT; returns {p, g}. Targets and partners never overlap
   // within a level, so updating in place is safe.
   function automatic logic [2*WIDTH-1:0] prefix_lo(input logic [WIDTH-1:0] p_in,
                                                     input logic [WIDTH-1:0] g_in);
      logic [WIDTH-1:0] p_t;
      logic [WIDTH-1:0] g_t;
      logic [1:0]       gp;
      p_t = p_in;
      g_t = g_in;
      for (int l = 1; l <= SPLIT; l++) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (((i + 1) % (1 << l)) == 0) begin
               gp     = bk_dot(g_t[i], p_t[i], g_t[i - (1 << (l - 1))], p_t[i - (1 << (l - 1))]);
               g_t[i] = gp[1];
               p_t[i] = gp[0];
            end
         end
      end
      return {p_t, g_t};
   endfunction

   // Remaining forward levels then the reverse tree; returns group generate G[i:0].
   function automatic logic [WIDTH-1:0] prefix_hi(input logic [WIDTH-1:0] p_in,
                                                   input logic [WIDTH-1:0] g_in);
      logic [WIDTH-1:0] p_t;
      logic [WIDTH-1:0] g_t;
      logic [1:0]       gp;
      p_t = p_in;
      g_t = g_in;
      for (int l = SPLIT + 1; l <= LVLS; l++) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (((i + 1) % (1 << l)) == 0) begin
               gp     = bk_dot(g_t[i], p_t[i], g_t[i - (1 << (l - 1))], p_t[i - (1 << (l - 1))]);
               g_t[i] = gp[1];
               p_t[i] = gp[0];
            end
         end
      end
      for (int l = LVLS - 1; l >= 1; l--) begin
         for (int i = 0; i < WIDTH; i++) begin
            if ((i >= (1 << l)) && (((i + 1) % (1 << l)) == (1 << (l - 1)))) begin
               gp     = bk_dot(g_t[i], p_t[i], g_t[i - (1 << (l - 1))], p_t[i - (1 << (l - 1))]);
               g_t[i] = gp[1];
               p_t[i] = gp[0];
            end
         end
      end
      return g_t;
   endfunction

   logic v1, v2, v3;
   logic rdy1, rdy2, rdy3;

   // ---------------- S1: PG on (a, ~b), carry-in = ~bin
   logic [WIDTH-1:0] pg_p, pg_g;
   logic [S1_W-1:0]  s1_d, s1_q;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pg
      assign {pg_g[gi], pg_p[gi]} = bk_pg_cell(a[gi], ~b[gi]);
   end

   assign s1_d = {a[WIDTH-1], b[WIDTH-1], ~bin, pg_p, pg_g};

   bk_sub_stage_reg #(.DATA_W(S1_W), .RST_DATA(1'b0)) u_s1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (in_valid),
      .dn_ready (rdy2),
      .data_d   (s1_d),
      .valid    (v1),
      .ready    (rdy1),
      .data_q   (s1_q)
   );

   assign in_ready = rdy1;

   // ---------------- S2: carry-in folded into bit 0, lower forward levels
   logic             s1_a_msb, s1_b_msb, s1_c0;
   logic [WIDTH-1:0] s1_p, s1_g;
   logic [WIDTH-1:0] g_fold;
   logic [2*WIDTH-1:0] lo_pg;
   logic [S2_W-1:0]  s2_d, s2_q;

   assign {s1_a_msb, s1_b_msb, s1_c0, s1_p, s1_g} = s1_q;

   always_comb begin
      g_fold    = s1_g;
      g_fold[0] = s1_g[0] | (s1_p[0] & s1_c0);
      lo_pg     = prefix_lo(s1_p, g_fold);
   end

   // The untouched bit propagates ride along for the final sum XOR.
   assign s2_d = {s1_a_msb, s1_b_msb, s1_c0, s1_p, lo_pg};

   bk_sub_stage_reg #(.DATA_W(S2_W), .RST_DATA(1'b0)) u_s2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (v1),
      .dn_ready (rdy3),
      .data_d   (s2_d),
      .valid    (v2),
      .ready    (rdy2),
      .data_q   (s2_q)
   );

   // ---------------- S3: upper forward levels, reverse tree, sum and flags
   logic             s2_a_msb, s2_b_msb, s2_c0;
   logic [WIDTH-1:0] s2_p0, s2_lp, s2_lg;
   logic [WIDTH-1:0] carry_g, raw_diff, diff_d;
   logic             borrow_d, ovf_d, zero_d;
   logic [S3_W-1:0]  s3_d, s3_q;

   assign {s2_a_msb, s2_b_msb, s2_c0, s2_p0, s2_lp, s2_lg} = s2_q;

   always_comb begin
      carry_g  = prefix_hi(s2_lp, s2_lg);
      raw_diff = s2_p0 ^ {carry_g[WIDTH-2:0], s2_c0};
      borrow_d = ~carry_g[WIDTH-1];
      ovf_d    = (s2_a_msb ^ s2_b_msb) & (s2_a_msb ^ raw_diff[WIDTH-1]);
`ifdef BK_SUB_SATURATE_EN
      if (ovf_d) begin
         diff_d = s2_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         diff_d = raw_diff;
      end
`else
      diff_d = raw_diff;
`endif
      zero_d = ~|diff_d;
   end

   assign s3_d = {borrow_d, ovf_d, zero_d, diff_d};

   bk_sub_stage_reg #(.DATA_W(S3_W), .RST_DATA(1'b1)) u_s3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (v2),
      .dn_ready (out_ready),
      .data_d   (s3_d),
      .valid    (v3),
      .ready    (rdy3),
      .data_q   (s3_q)
   );

   assign out_valid = v3;
   assign {borrow, ovf, zero, diff} = s3_q;

endmodule
